// File: rtl/cpu_mem_pkg.sv
// Shared store-path definitions: access-size encodings, packer FSM states and
// small lane arithmetic helpers used by store_lane_packer and lane_mapper.
package cpu_mem_pkg;

   localparam int BYTES_PER_WORD = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BEAT0 = 2'b01,
      ST_BEAT1 = 2'b10,
      ST_ERR   = 2'b11
   } packer_state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   // True when the requested bytes run past the last lane of the word.
   function automatic logic crosses_word(input logic [1:0] offset, input logic [1:0] size);
      crosses_word = ({1'b0, offset} + size_bytes(size)) > 3'(BYTES_PER_WORD);
   endfunction

endpackage

// File: rtl/lane_mapper.sv
// Combinational byte-lane placement: builds the byte enables and lane-aligned
// write data for one beat of a store, given the byte offset, size and beat index.
module lane_mapper
   import cpu_mem_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic [31:0] data,
   input  logic        beat,
   output logic [3:0]  be,
   output logic [31:0] wdata
);

   logic [3:0]  nmask;
   logic [7:0]  lane_mask;
   logic [31:0] data_m;
   logic [63:0] placed;

   always_comb begin
      nmask  = 4'b1111;
      data_m = '0;
      case (size)
         SZ_BYTE: nmask = 4'b0001;
         SZ_HALF: nmask = 4'b0011;
         default: nmask = 4'b1111;
      endcase
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         data_m[8*k +: 8] = nmask[k] ? data[8*k +: 8] : 8'h00;
      end
   end

   // Two-word window: the upper word holds whatever spills into the next beat.
   assign lane_mask = {4'b0000, nmask} << offset;
   assign placed    = {32'h0000_0000, data_m} << {offset, 3'b000};

   assign be    = beat ? lane_mask[7:4] : lane_mask[3:0];
   assign wdata = beat ? placed[63:32]  : placed[31:0];

endmodule

// File: rtl/store_lane_packer.sv
// Store-side packer: narrows a register operand onto data-memory byte lanes.
// Define MISALIGN_SPLIT_EN to split word-crossing half/word stores into two beats.
module store_lane_packer
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_data,
   input  logic [1:0]        in_size,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              err
);

   packer_state_t state, state_nxt;

   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [1:0]        size_q;
   logic              accept;
   logic              legal;
   logic              beat;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [ADDR_W-1:0] word_addr;

   assign accept = in_valid && in_ready;

`ifdef MISALIGN_SPLIT_EN
   assign legal = (in_size != SZ_RSVD);
   assign beat  = (state == ST_BEAT1);
`else
   assign legal = (in_size != SZ_RSVD) && !crosses_word(in_addr[1:0], in_size);
   assign beat  = 1'b0;
`endif

   // Request capture is data only; the control state alone carries reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= in_addr;
         data_q <= in_data;
         size_q <= in_size;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = legal ? ST_BEAT0 : ST_ERR;
`ifdef MISALIGN_SPLIT_EN
         ST_BEAT0: if (mem_ready) state_nxt = crosses_word(addr_q[1:0], size_q) ? ST_BEAT1 : ST_IDLE;
         ST_BEAT1: if (mem_ready) state_nxt = ST_IDLE;
`else
         ST_BEAT0: if (mem_ready) state_nxt = ST_IDLE;
`endif
         default:  state_nxt = ST_IDLE;
      endcase
   end

   lane_mapper u_lane_mapper (
      .offset (addr_q[1:0]),
      .size   (size_q),
      .data   (data_q),
      .beat   (beat),
      .be     (be),
      .wdata  (wdata)
   );

   // Second beat targets the following word, wrapping at the top of the space.
   assign word_addr = beat ? {addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00}
                           : {addr_q[ADDR_W-1:2], 2'b00};

   assign in_ready  = (state == ST_IDLE) && !rst;
   assign mem_valid = (state == ST_BEAT0) || (state == ST_BEAT1);
   assign err       = (state == ST_ERR);
   assign mem_addr  = mem_valid ? word_addr : '0;
   assign mem_be    = mem_valid ? be : 4'b0000;
   assign mem_wdata = mem_valid ? wdata : 32'h0000_0000;

endmodule
